// File: rtl/output_vc_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : output_vc_scheduler_if
// Description : Requester/credit/grant bundle for one output-port scheduler.
//               The master drives requests and credit returns; the slave
//               (scheduler) answers with grants, VC binding and error status.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_vc_scheduler_if #(
  parameter int NUM_INPUTS        = 6,
  parameter int LANES_PER_CHANNEL = 2
);
  localparam int c_VC_W = (LANES_PER_CHANNEL > 1) ? $clog2(LANES_PER_CHANNEL) : 1;

  logic [NUM_INPUTS-1:0]        req;
  logic [NUM_INPUTS-1:0]        req_head;
  logic [NUM_INPUTS-1:0]        req_tail;
  logic [LANES_PER_CHANNEL-1:0] credit_in;
  logic [NUM_INPUTS-1:0]        grant;
  logic [c_VC_W-1:0]            grant_vc;
  logic [LANES_PER_CHANNEL-1:0] vc_busy;
  logic                         err_protocol;
  logic                         err_credit;

  modport master (
    output req, req_head, req_tail, credit_in,
    input  grant, grant_vc, vc_busy, err_protocol, err_credit
  );

  modport slave (
    input  req, req_head, req_tail, credit_in,
    output grant, grant_vc, vc_busy, err_protocol, err_credit
  );
endinterface
`default_nettype wire

// File: rtl/output_vc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : output_vc_scheduler
// Description : Per-output-port scheduler. Round-robin shares the output link
//               among requesters, binds packets to downstream VCs from head
//               to tail, and tracks per-VC credits. One flit grant per cycle,
//               granted combinationally in the cycle it is requested.
// Revision    : 1.0 - initial release
// ============================================================================
module output_vc_scheduler #(
  parameter int NUM_INPUTS        = 6,
  parameter int LANES_PER_CHANNEL = 2,
  parameter int VC_DEPTH          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  output_vc_scheduler_if.slave bus
);
  localparam int c_IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int c_VC_W  = (LANES_PER_CHANNEL > 1) ? $clog2(LANES_PER_CHANNEL) : 1;
  localparam int c_CR_W  = $clog2(VC_DEPTH + 1);

  // Architectural state
  logic [LANES_PER_CHANNEL-1:0]             busy_q, busy_d;
  logic [LANES_PER_CHANNEL-1:0][c_IDX_W-1:0] owner_q, owner_d;
  logic [LANES_PER_CHANNEL-1:0][c_CR_W-1:0]  credit_q, credit_d;
  logic [c_IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
  logic                                     err_protocol_q, err_protocol_d;
  logic                                     err_credit_q, err_credit_d;

  // Per-requester eligibility and target VC
  logic [NUM_INPUTS-1:0]             w_owns;
  logic [NUM_INPUTS-1:0]             w_elig;
  logic [NUM_INPUTS-1:0]             w_proto;
  logic [NUM_INPUTS-1:0][c_VC_W-1:0] w_tgt;
  logic                              w_free_ok;
  logic [c_VC_W-1:0]                 w_free_vc;

  // Arbitration result
  logic               w_gnt_any;
  logic [c_IDX_W-1:0] w_gnt_idx;
  logic [c_VC_W-1:0]  w_gnt_vc;

  // Lowest-index free VC with credit, and per-requester ownership/eligibility
  always_comb begin
    w_free_ok = 1'b0;
    w_free_vc = '0;
    for (int v = LANES_PER_CHANNEL - 1; v >= 0; v--) begin
      if (!busy_q[v] && (credit_q[v] != '0)) begin
        w_free_ok = 1'b1;
        w_free_vc = c_VC_W'(v);
      end
    end
    w_owns  = '0;
    w_elig  = '0;
    w_proto = '0;
    w_tgt   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      logic own_ok;
      logic [c_VC_W-1:0] own_vc;
      own_ok = 1'b0;
      own_vc = '0;
      for (int v = 0; v < LANES_PER_CHANNEL; v++) begin
        if (busy_q[v] && (owner_q[v] == c_IDX_W'(i))) begin
          w_owns[i] = 1'b1;
          own_vc    = c_VC_W'(v);
          own_ok    = (credit_q[v] != '0);
        end
      end
      w_elig[i]  = bus.req[i] && (w_owns[i] ? own_ok : (bus.req_head[i] && w_free_ok));
      w_tgt[i]   = w_owns[i] ? own_vc : w_free_vc;
      w_proto[i] = bus.req[i] && !bus.req_head[i] && !w_owns[i];
    end
  end

  // Round-robin pick: first eligible requester starting at rr_ptr
  always_comb begin
    logic [c_IDX_W:0] scan;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt_vc  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan = {1'b0, rr_ptr_q} + (c_IDX_W + 1)'(k);
      if (scan >= (c_IDX_W + 1)'(NUM_INPUTS)) begin
        scan = scan - (c_IDX_W + 1)'(NUM_INPUTS);
      end
      if (!w_gnt_any && w_elig[scan[c_IDX_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = scan[c_IDX_W-1:0];
        w_gnt_vc  = w_tgt[scan[c_IDX_W-1:0]];
      end
    end
  end

  // Next state: credit accounting, VC binding/release, pointer and sticky errors
  always_comb begin
    busy_d         = busy_q;
    owner_d        = owner_q;
    credit_d       = credit_q;
    rr_ptr_d       = rr_ptr_q;
    err_protocol_d = err_protocol_q | (|w_proto);
    err_credit_d   = err_credit_q;
    for (int v = 0; v < LANES_PER_CHANNEL; v++) begin
      logic dec;
      dec = w_gnt_any && (w_gnt_vc == c_VC_W'(v));
      if (dec && !bus.credit_in[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (!dec && bus.credit_in[v]) begin
        if (credit_q[v] == c_CR_W'(VC_DEPTH)) begin
          err_credit_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + 1'b1;
        end
      end
    end
    if (w_gnt_any) begin
      rr_ptr_d = (w_gnt_idx == c_IDX_W'(NUM_INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (bus.req_head[w_gnt_idx]) begin
        busy_d[w_gnt_vc]  = 1'b1;
        owner_d[w_gnt_vc] = w_gnt_idx;
      end
      if (bus.req_tail[w_gnt_idx]) begin
        busy_d[w_gnt_vc] = 1'b0;
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= '0;
      owner_q        <= '0;
      credit_q       <= {LANES_PER_CHANNEL{c_CR_W'(VC_DEPTH)}};
      rr_ptr_q       <= '0;
      err_protocol_q <= 1'b0;
      err_credit_q   <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      owner_q        <= owner_d;
      credit_q       <= credit_d;
      rr_ptr_q       <= rr_ptr_d;
      err_protocol_q <= err_protocol_d;
      err_credit_q   <= err_credit_d;
    end
  end

  // Outputs: grants are forced idle while reset is held
  always_comb begin
    bus.grant    = '0;
    bus.grant_vc = '0;
    if (w_gnt_any && !reset) begin
      bus.grant[w_gnt_idx] = 1'b1;
      bus.grant_vc         = w_gnt_vc;
    end
    bus.vc_busy      = busy_q;
    bus.err_protocol = err_protocol_q;
    bus.err_credit   = err_credit_q;
  end
endmodule
`default_nettype wire
